// File: rtl/led_bank_arbiter_if.sv
// LED bank sharing bus: HPS and fabric request inputs, grant/drive outputs.
interface led_bank_arbiter_if #(
  parameter int NREQ = 4
);
  logic [7:0]        hps_led;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_led;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        led;
  logic              busy;

  modport master (
    output hps_led, req, req_led,
    input  gnt, led, busy
  );

  modport slave (
    input  hps_led, req, req_led,
    output gnt, led, busy
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// Shares the 8-bit LED bank between the HPS PIO and NREQ fabric requesters
// using round-robin arbitration with a minimum visible hold time.
//
// state   | meaning
// S_IDLE  | HPS owns the bank, led follows hps_led
// S_GRANT | requester 'owner' owns the bank, led follows its pattern
module led_bank_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic               clk_clk,
  input logic               reset_reset,
  led_bank_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  // Returns {found, index} of the first set bit of mask scanning from start.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] mask,
                                         input logic [IW-1:0]   start);
    logic          found;
    logic [IW-1:0] sel;
    logic [IW-1:0] ci;
    int            c;
    found = 1'b0;
    sel   = '0;
    for (int o = 0; o < NREQ; o++) begin
      c = int'(start) + o;
      if (c >= NREQ) c = c - NREQ;
      ci = c[IW-1:0];
      if (!found && mask[ci]) begin
        found = 1'b1;
        sel   = ci;
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    if (idx == IW'(NREQ - 1)) return '0;
    return idx + IW'(1);
  endfunction

  state_t        state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [7:0]    led_q, led_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic          busy_q, busy_n;

  logic [7:0]      pat [NREQ];
  logic [NREQ-1:0] own_oh;
  logic [IW:0]     pick_all, pick_oth;
  logic            hold_done;
  logic            take;
  logic [IW-1:0]   take_idx;

  always_comb begin
    for (int k = 0; k < NREQ; k++) pat[k] = bus.req_led[8*k +: 8];
  end

  assign own_oh    = NREQ'(1) << owner;
  assign pick_all  = rr_pick(bus.req, ptr);
  assign pick_oth  = rr_pick(bus.req & ~own_oh, ptr);
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    ptr_n    = ptr;
    hold_n   = hold_cnt;
    led_n    = led_q;
    take     = 1'b0;
    take_idx = '0;

    case (state)
      S_IDLE: begin
        led_n = bus.hps_led;
        if (pick_all[IW]) begin
          take     = 1'b1;
          take_idx = pick_all[IW-1:0];
        end
      end
      S_GRANT: begin
        if (!bus.req[owner]) begin
          if (pick_oth[IW]) begin
            take     = 1'b1;
            take_idx = pick_oth[IW-1:0];
          end else begin
            state_n = S_IDLE;
            led_n   = bus.hps_led;
          end
        end else if (hold_done && pick_oth[IW]) begin
          take     = 1'b1;
          take_idx = pick_oth[IW-1:0];
        end else begin
          led_n = pat[owner];
          if (!hold_done) hold_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A new grant restarts the hold window and advances the rotation.
    if (take) begin
      state_n = S_GRANT;
      owner_n = take_idx;
      ptr_n   = wrap_inc(take_idx);
      hold_n  = '0;
      led_n   = pat[take_idx];
    end

    gnt_n  = (state_n == S_GRANT) ? (NREQ'(1) << owner_n) : '0;
    busy_n = (state_n == S_GRANT);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= S_IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      led_q    <= 8'h00;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      led_q    <= led_n;
      gnt_q    <= gnt_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.led  = led_q;
  assign bus.busy = busy_q;
endmodule
